// File: rtl/px_clint_pkg.sv
// Shared definitions for px_clint: register offsets, reset constants, bus FSM
// states and the byte-lane merge helper.
package px_clint_pkg;

    localparam logic [4:0] OFF_MSIP        = 5'h00;
    localparam logic [4:0] OFF_EXT_EN      = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h10;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h14;
    localparam logic [4:0] OFF_EXT_PEND    = 5'h18;
    localparam logic [4:0] OFF_UNMAPPED    = 5'h1C;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } bus_state_t;

    // be[b] selects byte b of new_val, otherwise the old byte is kept.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/px_clint_sync.sv
// One-bit two-flop synchronizer with rising-edge detect on the synchronized value.
module px_clint_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh <= '0;
        else      sh <= {sh[1:0], async_in};
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/px_clint.sv
// Memory-mapped timer / software / external interrupt source on the px_rv32
// native bus. Interrupt outputs are registered levels.
module px_clint
    import px_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          PRESCALE  = 1,
    parameter int          NUM_EXT   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic               l8,
    input  logic               l16,
    input  logic               h24,
    input  logic               h32,
    output logic               rdy,
    output logic               acc_fault,
    input  logic [NUM_EXT-1:0] ext_irq,
    output logic               timer_int,
    output logic               soft_int,
    output logic               ext_int,
    output bus_state_t         bus_state
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // Handshake: a strobe seen low in IDLE is answered by exactly one rdy
    // cycle (acc_fault alongside on a fault); the master keeps the strobe low
    // until rdy, and the FSM waits in HOLD until both strobes are high again.
    bus_state_t state, state_nx;

    logic [4:0]  off;
    logic [3:0]  be;
    logic        in_win, fault, accept, wr_en;
    logic [31:0] rd_val;

    logic               msip;
    logic [NUM_EXT-1:0] ext_en, ext_pend, ext_rise, pend_clr;
    logic [63:0]        mtimecmp, mtime;
    logic [15:0]        presc;

    assign off    = addr[4:0];
    assign be     = {h32, h24, l16, l8};
    assign in_win = (addr[31:5] == BASE_ADDR[31:5]);
    assign fault  = (off == OFF_UNMAPPED) || (!rd_n && !wr_n) || (addr[1:0] != 2'b00);
    assign accept = (state == ST_IDLE) && in_win && (!rd_n || !wr_n);
    assign wr_en  = accept && !fault && !wr_n;
    assign bus_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_HOLD;
            ST_HOLD: if (rd_n && wr_n) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_MSIP:        rd_val = {31'b0, msip};
            OFF_EXT_EN:      rd_val = {{(32-NUM_EXT){1'b0}}, ext_en};
            OFF_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            OFF_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            OFF_MTIME_LO:    rd_val = mtime[31:0];
            OFF_MTIME_HI:    rd_val = mtime[63:32];
            OFF_EXT_PEND:    rd_val = {{(32-NUM_EXT){1'b0}}, ext_pend};
            default:         rd_val = '0;
        endcase
    end

    // Response is registered at the accepting edge, so it lands in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy       <= 1'b0;
            acc_fault <= 1'b0;
            data_o    <= '0;
        end else begin
            rdy       <= accept;
            acc_fault <= accept && fault;
            data_o    <= (accept && !fault && !rd_n) ? rd_val : '0;
        end
    end

    // NUM_EXT never exceeds 8, so only lane 0 carries EXT_EN / EXT_PEND bits.
    assign pend_clr = (wr_en && off == OFF_EXT_PEND && l8) ? data_i[NUM_EXT-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip     <= 1'b0;
            ext_en   <= '0;
            ext_pend <= '0;
            mtimecmp <= MTIMECMP_RST;
        end else begin
            if (wr_en && off == OFF_MSIP && l8)   msip   <= data_i[0];
            if (wr_en && off == OFF_EXT_EN && l8) ext_en <= data_i[NUM_EXT-1:0];
            if (wr_en && off == OFF_MTIMECMP_LO)
                mtimecmp[31:0] <= lane_merge(mtimecmp[31:0], data_i, be);
            if (wr_en && off == OFF_MTIMECMP_HI)
                mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], data_i, be);
            ext_pend <= (ext_pend & ~pend_clr) | ext_rise;
        end
    end

    // A bus write to either mtime half suppresses that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
            presc <= '0;
        end else if (wr_en && off == OFF_MTIME_LO) begin
            mtime[31:0] <= lane_merge(mtime[31:0], data_i, be);
            presc       <= '0;
        end else if (wr_en && off == OFF_MTIME_HI) begin
            mtime[63:32] <= lane_merge(mtime[63:32], data_i, be);
            presc        <= '0;
        end else if (presc == PRESC_LAST) begin
            mtime <= mtime + 64'd1;
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_int <= 1'b0;
            soft_int  <= 1'b0;
            ext_int   <= 1'b0;
        end else begin
            timer_int <= (mtime >= mtimecmp);
            soft_int  <= msip;
            ext_int   <= |(ext_pend & ext_en);
        end
    end

    for (genvar i = 0; i < NUM_EXT; i++) begin : g_sync
        px_clint_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (ext_irq[i]),
            .rise     (ext_rise[i])
        );
    end

endmodule
